// File: rtl/alu_mdu_pkg.sv
// alu_mdu_pkg
//   Shared definitions for the ALU / multiply-divide unit:
//   opcode constants, controller state encoding, and a helper that
//   classifies opcodes as iterative (multi-cycle) or single-cycle.
package alu_mdu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_AND  = 4'b0001;
    localparam logic [3:0] OP_NOR  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_MULU = 4'b1011;
    localparam logic [3:0] OP_DIVU = 4'b1100;
    localparam logic [3:0] OP_REMU = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_iter_op(input logic [3:0] op);
        return (op == OP_MULU) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_mdu_iter.sv
// alu_mdu_iter
//   Bit-serial unsigned multiply (shift-add) and restoring divide,
//   one bit per clock, WIDTH iterations per operation.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset (control only)
//   i_start           load operands and begin an operation
//   i_op              OP_MULU / OP_DIVU / OP_REMU
//   i_a, i_b          operands (multiplicand/multiplier, dividend/divisor)
//   o_done            one-cycle pulse, result valid on o_result
//   o_result          low product, quotient or remainder
module alu_mdu_iter
    import alu_mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result
);
    localparam int CW = $clog2(WIDTH);

    logic             r_busy;
    logic             r_done;
    logic [CW-1:0]    r_cnt;
    logic [3:0]       r_op;
    // r_acc: product accumulator / partial remainder
    // r_x  : shifting multiplicand / dividend-into-quotient register
    // r_y  : shifting multiplier / divisor
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;

    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH:0]   w_sub;
    logic             w_is_mul;

    // Restoring step: bring next dividend bit into the remainder and
    // subtract the divisor only when it fits. A zero divisor always fits,
    // which naturally yields an all-ones quotient and remainder == dividend.
    assign w_shift  = {r_acc, r_x[WIDTH-1]};
    assign w_ge     = (w_shift >= {1'b0, r_y});
    assign w_sub    = w_shift - {1'b0, r_y};
    assign w_is_mul = (r_op == OP_MULU);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_done <= 1'b0;
            r_cnt  <= '0;
        end else if (r_busy) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CW'(WIDTH - 1)) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end else begin
            r_done <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (i_start) begin
            r_op  <= i_op;
            r_acc <= '0;
            r_x   <= i_a;
            r_y   <= i_b;
        end else if (r_busy) begin
            if (w_is_mul) begin
                r_acc <= r_acc + (r_y[0] ? r_x : '0);
                r_x   <= r_x << 1;
                r_y   <= r_y >> 1;
            end else begin
                r_acc <= w_ge ? w_sub[WIDTH-1:0] : w_shift[WIDTH-1:0];
                r_x   <= {r_x[WIDTH-2:0], w_ge};
            end
        end
    end

    assign o_done   = r_done;
    assign o_result = (r_op == OP_DIVU) ? r_x : r_acc;

endmodule

// File: rtl/alu_mdu.sv
// alu_mdu
//   ALU with iterative unsigned multiply/divide behind a valid/ready
//   handshake. Single-cycle ops deliver one cycle after accept; MULU,
//   DIVU and REMU deliver WIDTH+1 cycles after accept.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid / in_ready     request handshake
//   alu_src_a, alu_src_b    operands, ALUOp opcode (captured on accept)
//   out_valid / out_ready   result handshake
//   alu_output, Zero,       registered result and flags, held while
//   Overflow                out_valid && !out_ready
module alu_mdu
    import alu_mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] alu_src_a,
    input  logic [WIDTH-1:0] alu_src_b,
    input  logic [3:0]       ALUOp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_output,
    output logic             Zero,
    output logic             Overflow
);
    localparam int SHW = $clog2(WIDTH);

    state_t           r_state;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_ovf;

    logic             w_accept;
    logic             w_iter_start;
    logic             w_iter_done;
    logic [WIDTH-1:0] w_iter_res;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;

    // Signed overflow: operands agree in sign but the result does not.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                        input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    // Gated by rst_n so nothing is offered during the reset cycle.
    assign in_ready     = rst_n && ((r_state == ST_IDLE) ||
                                    ((r_state == ST_DONE) && out_ready));
    assign w_accept     = in_valid && in_ready;
    assign w_iter_start = w_accept && is_iter_op(ALUOp);

    assign w_sum   = alu_src_a + alu_src_b;
    assign w_diff  = alu_src_a - alu_src_b;
    assign w_shamt = alu_src_b[SHW-1:0];

    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        case (ALUOp)
            OP_ADD: begin
                w_res = w_sum;
                w_ovf = signed_ovf(alu_src_a[WIDTH-1], alu_src_b[WIDTH-1], w_sum[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = w_diff;
                w_ovf = signed_ovf(alu_src_a[WIDTH-1], ~alu_src_b[WIDTH-1], w_diff[WIDTH-1]);
            end
            OP_AND:  w_res = alu_src_a & alu_src_b;
            OP_NOR:  w_res = ~(alu_src_a | alu_src_b);
            OP_OR:   w_res = alu_src_a | alu_src_b;
            OP_XOR:  w_res = alu_src_a ^ alu_src_b;
            OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (alu_src_a < alu_src_b)};
            OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(alu_src_a) < $signed(alu_src_b))};
            OP_SLL:  w_res = alu_src_a << w_shamt;
            OP_SRL:  w_res = alu_src_a >> w_shamt;
            OP_SRA:  w_res = WIDTH'($signed(alu_src_a) >>> w_shamt);
            default: w_res = '0;
        endcase
    end

    alu_mdu_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_iter_start),
        .i_op     (ALUOp),
        .i_a      (alu_src_a),
        .i_b      (alu_src_b),
        .o_done   (w_iter_done),
        .o_result (w_iter_res)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b1;
            r_ovf       <= 1'b0;
        end else if (w_accept) begin
            // Accept is possible from IDLE or from DONE with out_ready.
            if (is_iter_op(ALUOp)) begin
                r_state     <= ST_BUSY;
                r_out_valid <= 1'b0;
            end else begin
                r_state     <= ST_DONE;
                r_out_valid <= 1'b1;
                r_result    <= w_res;
                r_zero      <= (w_res == '0);
                r_ovf       <= w_ovf;
            end
        end else begin
            case (r_state)
                ST_BUSY: begin
                    if (w_iter_done) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_result    <= w_iter_res;
                        r_zero      <= (w_iter_res == '0);
                        r_ovf       <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_valid  = r_out_valid;
    assign alu_output = r_result;
    assign Zero       = r_zero;
    assign Overflow   = r_ovf;

endmodule

// File: tb/tb_alu_mdu.sv
module tb_alu_mdu;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_src_a;
    logic [31:0] alu_src_b;
    logic [3:0]  ALUOp;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_output;
    logic        Zero;
    logic        Overflow;

    int n_tests = 0;
    int n_fail  = 0;

    alu_mdu #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .ALUOp      (ALUOp),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_output (alu_output),
        .Zero       (Zero),
        .Overflow   (Overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alu_src_a = '0; alu_src_b = '0; ALUOp = 4'b0000;
        tick();
        tick();
        n_tests++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        n_tests++;
        if (out_valid !== 1'b0 || alu_output !== 32'h0 || Zero !== 1'b1 || Overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got v=%b r=%h z=%b o=%b exp v=0 r=0 z=1 o=0",
                     out_valid, alu_output, Zero, Overflow);
        end
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_add_ovf();
        alu_src_a = 32'h7FFF_FFFF; alu_src_b = 32'h1; ALUOp = 4'b0000;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1 || alu_output !== 32'h8000_0000 || Overflow !== 1'b1 || Zero !== 1'b0) begin
            n_fail++;
            $display("FAIL add_ovf got v=%b r=%h o=%b z=%b exp v=1 r=80000000 o=1 z=0",
                     out_valid, alu_output, Overflow, Zero);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_drain got v=%b exp=0", out_valid); end
    endtask

    task automatic test_single_ops();
        logic [3:0]  t_op  [13] = '{4'b0101, 4'b0101, 4'b0001, 4'b0010, 4'b0100, 4'b0110,
                                    4'b0111, 4'b0011, 4'b1000, 4'b1001, 4'b1010, 4'b1110, 4'b1111};
        logic [31:0] t_a   [13] = '{32'h3, 32'h8000_0000, 32'hF0F0_F0F0, 32'h0, 32'h0F0, 32'hFFFF_0000,
                                    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'h8000_0000, 32'h8000_0000,
                                    32'h12345, 32'hFFFF_FFFF};
        logic [31:0] t_b   [13] = '{32'h5, 32'h1, 32'hFF00_FF00, 32'h0, 32'hF00, 32'hFF00_FF00,
                                    32'h1, 32'h1, 32'h3F, 32'h4, 32'h21, 32'h678, 32'h1};
        logic [31:0] t_exp [13] = '{32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'hF000_F000, 32'hFFFF_FFFF, 32'hFF0,
                                    32'h00FF_FF00, 32'h1, 32'h0, 32'h8000_0000, 32'h0800_0000,
                                    32'hC000_0000, 32'h0, 32'h0};
        logic        t_ovf [13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                    1'b0, 1'b0, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            alu_src_a = t_a[i]; alu_src_b = t_b[i]; ALUOp = t_op[i];
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            n_tests++;
            if (out_valid !== 1'b1 || alu_output !== t_exp[i] || Overflow !== t_ovf[i] ||
                Zero !== (t_exp[i] == 32'h0)) begin
                n_fail++;
                $display("FAIL single_op[%0d] op=%b got v=%b r=%h o=%b z=%b exp v=1 r=%h o=%b z=%b",
                         i, t_op[i], out_valid, alu_output, Overflow, Zero,
                         t_exp[i], t_ovf[i], (t_exp[i] == 32'h0));
            end
            tick();
        end
    endtask

    task automatic test_mulu();
        int cyc = 0;
        logic ready_seen = 1'b0;
        alu_src_a = 32'h0001_0000; alu_src_b = 32'h0001_0001; ALUOp = 4'b1011;
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        // Keep requesting with scrambled operands while busy: must be ignored.
        alu_src_a = 32'hDEAD_BEEF; alu_src_b = 32'h1234_5678; ALUOp = 4'b0000;
        while (!out_valid && cyc < 40) begin
            if (in_ready !== 1'b0) ready_seen = 1'b1;
            tick();
            cyc++;
        end
        n_tests++;
        if (ready_seen !== 1'b0) begin n_fail++; $display("FAIL mulu_busy_in_ready got=1 exp=0"); end
        n_tests++;
        if (cyc != 33) begin n_fail++; $display("FAIL mulu_latency got=%0d exp=33", cyc); end
        n_tests++;
        if (out_valid !== 1'b1 || alu_output !== 32'h0001_0000 || Overflow !== 1'b0 || Zero !== 1'b0) begin
            n_fail++;
            $display("FAIL mulu_result got v=%b r=%h o=%b z=%b exp v=1 r=00010000 o=0 z=0",
                     out_valid, alu_output, Overflow, Zero);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mulu_no_dup got v=%b exp=0", out_valid); end
    endtask

    task automatic test_div();
        logic [3:0]  d_op  [4] = '{4'b1100, 4'b1101, 4'b1100, 4'b1101};
        logic [31:0] d_a   [4] = '{32'd100, 32'd100, 32'd5, 32'd5};
        logic [31:0] d_b   [4] = '{32'd7, 32'd7, 32'd0, 32'd0};
        logic [31:0] d_exp [4] = '{32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int cyc = 0;
            alu_src_a = d_a[i]; alu_src_b = d_b[i]; ALUOp = d_op[i];
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            while (!out_valid && cyc < 40) begin
                tick();
                cyc++;
            end
            n_tests++;
            if (cyc != 33 || alu_output !== d_exp[i] || Zero !== 1'b0) begin
                n_fail++;
                $display("FAIL div[%0d] op=%b got cyc=%0d r=%h z=%b exp cyc=33 r=%h z=0",
                         i, d_op[i], cyc, alu_output, Zero, d_exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic held_ok = 1'b1;
        alu_src_a = 32'd5; alu_src_b = 32'd5; ALUOp = 4'b0101;
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            alu_src_a = 32'hA5A5_0000 + i; ALUOp = 4'b0000;
            if (out_valid !== 1'b1 || alu_output !== 32'h0 || Zero !== 1'b1 || Overflow !== 1'b0)
                held_ok = 1'b0;
            tick();
        end
        n_tests++;
        if (held_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_hold got v=%b r=%h z=%b exp v=1 r=0 z=1", out_valid, alu_output, Zero);
        end
        alu_src_a = 32'd2; alu_src_b = 32'd3; ALUOp = 4'b0000;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1 || alu_output !== 32'd5 || Zero !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_next got v=%b r=%h z=%b exp v=1 r=5 z=0", out_valid, alu_output, Zero);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got v=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_mid();
        logic stale = 1'b0;
        alu_src_a = 32'd100; alu_src_b = 32'd7; ALUOp = 4'b1100;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_state got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready);
        end
        for (int i = 0; i < 40; i++) begin
            if (out_valid !== 1'b0) stale = 1'b1;
            tick();
        end
        n_tests++;
        if (stale !== 1'b0) begin n_fail++; $display("FAIL midreset_stale got out_valid=1 exp=0"); end
    endtask

    initial begin
        test_reset();
        test_add_ovf();
        test_single_ops();
        test_mulu();
        test_div();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
